systolic_feed_sequencer: RTL

Job-level controller that sequences one matrix-multiply pass through the input skew stage and the systolic array. On `start` it runs these phases in order:
- clears the PE accumulators and flushes the skew registers;
- issues K sequential reads from the operand buffer, with the skew `load_en` aligned to the buffer's 1-cycle read latency;
- waits the pipeline drain time;
- pulses `result_valid` / `done`.

It sits between the top-level command interface and the skew/array/operand-buffer datapath.

---
 rtl/systolic_feed_sequencer_if.sv | 31 +++
 rtl/systolic_feed_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/systolic_feed_sequencer_if.sv
// Command and datapath-control bundle for the systolic feed sequencer.
// master = job issuer / datapath side, slave = sequencer.
interface systolic_feed_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
);
    logic                  start;
    logic                  abort;
    logic [LEN_WIDTH-1:0]  k_len;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  busy;
    logic                  done;
    logic                  result_valid;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  skew_load_en;
    logic                  skew_flush;
    logic                  pe_clear;

    modport master (
        output start, abort, k_len, base_addr,
        input  busy, done, result_valid, rd_en, rd_addr,
        input  skew_load_en, skew_flush, pe_clear
    );

    modport slave (
        input  start, abort, k_len, base_addr,
        output busy, done, result_valid, rd_en, rd_addr,
        output skew_load_en, skew_flush, pe_clear
    );
endinterface

// File: rtl/systolic_feed_sequencer.sv
// Job sequencer for one matmul pass: clear, K operand fetches, drain, done.
// All outputs are registered; skew load trails the buffer read by one cycle.
module systolic_feed_sequencer #(
    parameter int ARRAY_SIZE = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst_n,
    systolic_feed_sequencer_if.slave bus
);
    localparam int DRAIN_LEN = 2 * ARRAY_SIZE;
    localparam int DW        = $clog2(DRAIN_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_k;
    logic [LEN_WIDTH-1:0]  r_idx;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DW-1:0]         r_drain;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rv;
    logic                  r_rd_en;
    logic                  r_sle;
    logic                  r_flush;
    logic                  r_clr;

    logic w_last_fetch;
    logic w_last_drain;
    logic w_abort;

    assign w_last_fetch = (r_idx == (r_k - LEN_WIDTH'(1)));
    assign w_last_drain = (r_drain == DW'(DRAIN_LEN - 1));
    assign w_abort      = bus.abort &&
                          ((r_state == S_CLEAR) ||
                           (r_state == S_FETCH) ||
                           (r_state == S_DRAIN));

    // State machine with registered Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_idx   <= '0;
            r_base  <= '0;
            r_addr  <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rv    <= 1'b0;
            r_rd_en <= 1'b0;
            r_sle   <= 1'b0;
            r_flush <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_clr   <= 1'b0;
            r_flush <= 1'b0;
            r_done  <= 1'b0;
            r_rv    <= 1'b0;
            r_sle   <= r_rd_en;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_rd_en <= 1'b0;
                r_sle   <= 1'b0;
                r_flush <= 1'b1;
            end else begin
                unique case (r_state)
                    // DONE also samples start so a held start chains jobs
                    // with no idle gap.
                    S_IDLE, S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_rd_en <= 1'b0;
                        if (bus.start) begin
                            r_busy <= 1'b1;
                            if (bus.k_len != '0) begin
                                r_state <= S_CLEAR;
                                r_k     <= bus.k_len;
                                r_base  <= bus.base_addr;
                                r_clr   <= 1'b1;
                                r_flush <= 1'b1;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_CLEAR: begin
                        r_state <= S_FETCH;
                        r_rd_en <= 1'b1;
                        r_addr  <= r_base;
                        r_idx   <= '0;
                    end
                    S_FETCH: begin
                        if (w_last_fetch) begin
                            r_state <= S_DRAIN;
                            r_rd_en <= 1'b0;
                            r_drain <= '0;
                        end else begin
                            r_idx  <= r_idx + LEN_WIDTH'(1);
                            r_addr <= r_addr + ADDR_WIDTH'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (w_last_drain) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_rv    <= 1'b1;
                        end else begin
                            r_drain <= r_drain + DW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_rd_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.result_valid = r_rv;
    assign bus.rd_en        = r_rd_en;
    assign bus.rd_addr      = r_addr;
    assign bus.skew_load_en = r_sle;
    assign bus.skew_flush   = r_flush;
    assign bus.pe_clear     = r_clr;
endmodule
